fpu_dot_seq: RTL
================

# fpu_dot_seq

Dot-product sequencer acting as the initiator for an `fpu_dsp` multiply-add instance. It accepts a stream of (x, y) `real_t` pairs terminated by a last flag and issues them to the DSP as `a·b+c`. Accumulation is spread over `LAT` interleaved partial-sum lanes so the DSP latency never stalls a dense stream. The lanes are then reduced through the same DSP to one IEEE-754 single-precision sum. The block sits between a vector source and one `fpu_dsp`, and owns the DSP's operand and result ports.

## Interface
- `LAT`, default `DSP_LATENCY` (fpu_pack): cycles from DSP `i_valid` to `o_valid`; also the number of partial-sum lanes; must be ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  input pair valid.
- `i_x`, `i_y`  in  `BW_DATA`  operands (`real_t`).
- `i_last`  in  1  marks the final pair of a vector; qualified by `i_valid`.
- `o_ready`  out  1  pair accepted when `i_valid && o_ready`.
- `o_dsp_valid`  out  1  drives DSP `i_valid`.
- `o_dsp_a`, `o_dsp_b`, `o_dsp_c`  out  `BW_DATA`  drive DSP `i_a`, `i_b`, `i_c`.
- `i_dsp_z`  in  `BW_DATA`  DSP `o_z`.
- `i_dsp_valid`  in  1  DSP `o_valid`.
- `o_sum`  out  `BW_DATA`  final dot product; held until the next result.
- `o_sum_valid`  out  1  one-cycle pulse when `o_sum` is updated.
- `o_busy`  out  1  high in every state except IDLE.
- `o_err`  out  1  sticky flag: `i_dsp_valid` differs from the internal tag-valid.

## Operation
- **State machine.** States are IDLE, ACCUM, DRAIN, REDUCE and DONE.
  - IDLE → ACCUM on the first accepted pair. At vector start all lanes are zeroed and their pending bits cleared.
  - ACCUM → DRAIN when a pair with `i_last` is accepted.
  - DRAIN → REDUCE when no lane is pending. DRAIN → DONE directly if `LAT`=1.
  - REDUCE → DONE when the (LAT−1)th reduction result returns.
  - DONE → IDLE after one cycle. `o_sum_valid`=1 in DONE.
- **Lane assignment.** Pair k of a vector uses lane k mod `LAT`. The lane counter wraps from `LAT`−1 to 0 and resets to 0 at vector start.
- **Issue.** An accepted pair issues the same cycle with a=x, b=y, c=`part[lane]`. A lane never written in this vector supplies +0 (0x00000000).
- **Ready.** `o_ready` = (state IDLE or ACCUM) and the current lane is not pending. A lane is also not pending if its result writes back in the same cycle. In that case c is forwarded from `i_dsp_z`, not from the register.
- **Tag pipeline.**
  - Every issue pushes {valid, lane, phase} into an internal `LAT`-deep shift register.
  - The output stage of this register qualifies the write-back of `i_dsp_z` into `part[lane]` and clears that lane's pending bit.
  - In the reduce phase the output stage instead loads the running accumulator `acc`.
- **Error check.** `i_dsp_valid` is only cross-checked against the tag valid. Any mismatch sets `o_err`, which stays set until `rst`.
- **Reduction.** Reduction is linear. Step j=1..LAT−1 issues a=(j=1 ? `part[0]` : `acc`), b=1.0 (0x3F800000), c=`part[j]`. Each step issues the cycle after the previous result returns; the first step issues on REDUCE entry. Multiplication by 1.0 is exact.
- **Output.** `o_sum` = final `acc`, or `part[0]` when `LAT`=1.
- **Reset.** Reset mid-operation clears state, lanes, pending bits, tag pipeline, `o_err` and `o_sum`. DSP results in flight at reset are dropped because their tags are gone; this does not set `o_err`.

## Timing
- **Reset values.** `o_ready`=0 during reset and 1 in the cycle after. `o_dsp_valid`=0, `o_dsp_a/b/c`=0, `o_sum`=0, `o_sum_valid`=0, `o_busy`=0, `o_err`=0.
- **Dense stream.** An unbroken stream is accepted at one pair per cycle with `o_ready` never dropping, because of same-cycle forwarding.
- **Latency.**
  - With a dense stream whose last pair is accepted at t0: REDUCE is entered at t0+LAT+1.
  - Each reduction step takes LAT+1 cycles.
  - `o_sum_valid` pulses at t0+LAT·LAT+LAT; for `LAT`=4 that is t0+20.
- **Sparse stream.** Gaps in the input only affect when DRAIN exits, which is the cycle after the last pending bit clears.
- **Back-pressure.** `o_ready`=0 from the cycle after `i_last` is accepted until IDLE. A new vector may be accepted the cycle after `o_sum_valid`.
- **Issue timing.** `o_dsp_*` are driven combinationally from the accepted pair and registered state; the DSP registers them.

## Test plan
- **Dense vector.** `LAT`=4, 8 back-to-back pairs (2.0, 3.0) = (0x40000000, 0x40400000) → `o_sum`=0x42400000 (48.0) at t0+20; `o_ready` high for all 8 cycles; `o_err`=0.
- **Single element.** One pair (3.0, 4.0) with `i_last` → `o_sum`=0x41400000 (12.0); `o_busy` high from acceptance until the DONE cycle.
- **Random gaps.** 5 pairs (1.0, 1.0), each followed by 0–6 idle cycles → `o_sum`=0x40A00000 (5.0). `o_ready` drops only when lane k mod 4 is pending.
- **Back-pressure.** Hold `i_valid`=1 with a second vector during DRAIN/REDUCE → no acceptance until after `o_sum_valid`; the second vector's sum is independent, i.e. lanes are re-zeroed.
- **Reset mid-vector.** Assert `rst` 2 cycles after accepting 3 pairs, then send (1.0, 2.0) with last → `o_sum`=0x40000000. Late DSP returns are ignored and `o_err`=0.
- **Protocol fault.** Inject `i_dsp_valid`=1 with no tag in flight → `o_err`=1 next cycle and stays set until `rst`.

Source files
------------

// File: rtl/fpu_dot_seq.sv
// ----------------------------------------------------------------------------
// fpu_dot_seq : dot-product sequencer driving one fpu_dsp multiply-add unit
// Rev 1.0     : interleaved partial-sum lanes, linear lane reduction
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_dot_seq #(
  parameter int LAT     = 4,
  parameter int BW_DATA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [BW_DATA-1:0] i_x,
  input  logic [BW_DATA-1:0] i_y,
  input  logic               i_last,
  output logic               o_ready,
  output logic               o_dsp_valid,
  output logic [BW_DATA-1:0] o_dsp_a,
  output logic [BW_DATA-1:0] o_dsp_b,
  output logic [BW_DATA-1:0] o_dsp_c,
  input  logic [BW_DATA-1:0] i_dsp_z,
  input  logic               i_dsp_valid,
  output logic [BW_DATA-1:0] o_sum,
  output logic               o_sum_valid,
  output logic               o_busy,
  output logic               o_err
);

  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int MW = $clog2(LAT + 1);
  localparam logic [BW_DATA-1:0] C_ONE      = BW_DATA'(32'h3F80_0000);
  localparam logic [LW-1:0]      C_LAST_IDX = LW'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_DRAIN  = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  logic [BW_DATA-1:0] r_part [LAT];
  logic [BW_DATA-1:0] r_acc;
  logic [BW_DATA-1:0] r_sum;
  logic [LAT-1:0]     r_pend;
  logic [LW-1:0]      r_lane;
  logic [LW-1:0]      r_step;
  logic               r_red_go;
  logic               r_err;
  logic [MW-1:0]      r_mask;
  logic               r_tv [LAT];
  logic [LW-1:0]      r_tl [LAT];
  logic               r_tp [LAT];

  logic           w_tag_v, w_tag_p, w_wb, w_red_ret, w_hit;
  logic [LW-1:0]  w_tag_l, w_lane_nxt;
  logic           w_accept, w_red_issue;
  logic [LAT-1:0] w_pend_nxt;

  assign w_tag_v   = r_tv[LAT-1];
  assign w_tag_l   = r_tl[LAT-1];
  assign w_tag_p   = r_tp[LAT-1];
  assign w_wb      = w_tag_v && !w_tag_p;
  assign w_red_ret = w_tag_v && w_tag_p;
  assign w_hit     = w_wb && (w_tag_l == r_lane);

  // A lane whose result lands this cycle is free again; its value is forwarded.
  assign o_ready = !rst && ((r_state == S_IDLE) || (r_state == S_ACCUM))
                   && (!r_pend[r_lane] || w_hit);
  assign w_accept    = i_valid && o_ready;
  assign w_red_issue = !rst && (r_state == S_REDUCE) && r_red_go;
  assign w_lane_nxt  = (r_lane == C_LAST_IDX) ? '0 : r_lane + 1'b1;

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wb)
      w_pend_nxt = w_pend_nxt & ~(LAT'(1) << w_tag_l);
    if (w_accept)
      w_pend_nxt = ((r_state == S_IDLE) ? '0 : w_pend_nxt) | (LAT'(1) << r_lane);
  end

  always_comb begin
    o_dsp_valid = w_accept || w_red_issue;
    o_dsp_a     = '0;
    o_dsp_b     = '0;
    o_dsp_c     = '0;
    if (w_accept) begin
      o_dsp_a = i_x;
      o_dsp_b = i_y;
      if (r_state == S_IDLE)
        o_dsp_c = '0;
      else if (w_hit)
        o_dsp_c = i_dsp_z;
      else
        o_dsp_c = r_part[r_lane];
    end else if (w_red_issue) begin
      o_dsp_a = (r_step == LW'(1)) ? r_part[0] : r_acc;
      o_dsp_b = C_ONE;
      o_dsp_c = r_part[r_step];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_sum    <= '0;
      r_pend   <= '0;
      r_lane   <= '0;
      r_step   <= LW'(1);
      r_red_go <= 1'b0;
      r_err    <= 1'b0;
      r_mask   <= MW'(LAT);
      for (int i = 0; i < LAT; i++) begin
        r_part[i] <= '0;
        r_tv[i]   <= 1'b0;
        r_tl[i]   <= '0;
        r_tp[i]   <= 1'b0;
      end
    end else begin
      r_tv[0] <= o_dsp_valid;
      r_tl[0] <= w_accept ? r_lane : r_step;
      r_tp[0] <= w_red_issue;
      for (int i = 1; i < LAT; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tl[i] <= r_tl[i-1];
        r_tp[i] <= r_tp[i-1];
      end
      r_pend <= w_pend_nxt;

      // Results still in flight from before reset arrive untagged; ignore them.
      if (r_mask != '0)
        r_mask <= r_mask - 1'b1;
      else if (i_dsp_valid != w_tag_v)
        r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < LAT; i++)
              r_part[i] <= '0;
            r_lane  <= w_lane_nxt;
            r_state <= i_last ? S_DRAIN : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_lane <= w_lane_nxt;
            if (i_last)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pend_nxt == '0) begin
            if (LAT == 1) begin
              r_sum   <= w_wb ? i_dsp_z : r_part[0];
              r_state <= S_DONE;
            end else begin
              r_step   <= LW'(1);
              r_red_go <= 1'b1;
              r_state  <= S_REDUCE;
            end
          end
        end
        S_REDUCE: begin
          if (w_red_issue)
            r_red_go <= 1'b0;
          if (w_red_ret) begin
            r_acc <= i_dsp_z;
            if (r_step == C_LAST_IDX) begin
              r_sum   <= i_dsp_z;
              r_state <= S_DONE;
            end else begin
              r_step   <= r_step + 1'b1;
              r_red_go <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_lane  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wb)
        r_part[w_tag_l] <= i_dsp_z;
    end
  end

  assign o_sum       = r_sum;
  assign o_sum_valid = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_err       = r_err;

endmodule

`default_nettype wire
